// File: rtl/sample_dma_requester.sv
// Per-voice DMA read requester: one request per valid voice per batch, batch handshake with the sample DMA receiver.
// Optional feature: define DMA_REQ_LOOP_EN for looped playback (voices reload start address and length at end of sample).
module sample_dma_requester #(
    parameter int unsigned NUM_VOICES = 64,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  voice_wr_en,
    output logic                  voice_wr_ready,
    input  logic [5:0]            voice_wr_id,
    input  logic [ADDR_WIDTH-1:0] voice_wr_addr,
    input  logic [23:0]           voice_wr_len,
    output logic                  req_tvalid,
    input  logic                  req_tready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [7:0]            req_len,
    output logic [5:0]            req_id,
    output logic                  last_request_sent,
    output logic [5:0]            last_request_id,
    output logic                  all_samples_invalid,
    input  logic                  all_samples_received
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT_RX
    } state_t;

    state_t state, state_next;

    logic [NUM_VOICES-1:0] voice_valid;
    logic [NUM_VOICES-1:0] valid_next;
    logic [ADDR_WIDTH-1:0] voice_ptr [NUM_VOICES];
    logic [23:0]           voice_rem [NUM_VOICES];
`ifdef DMA_REQ_LOOP_EN
    logic [ADDR_WIDTH-1:0] voice_start [NUM_VOICES];
    logic [23:0]           voice_len   [NUM_VOICES];
`endif

    logic [5:0]            idx;
    logic [5:0]            last_id;
    logic [5:0]            top_id;
    logic                  any_valid;
    logic                  wr_apply;
    logic                  hs;
    logic                  load_req;
    logic                  capture;
    logic                  idx_inc;
    logic                  last_hit;
    logic [7:0]            len_sel;
    logic [23:0]           hs_rem;
    logic [ADDR_WIDTH-1:0] ptr_inc;

    assign voice_wr_ready      = ((state == IDLE) || (state == WAIT_RX)) && !reset;
    assign wr_apply            = voice_wr_en && voice_wr_ready;
    assign all_samples_invalid = ~|voice_valid;
    assign hs                  = (state == ISSUE) && req_tvalid && req_tready && !stop;
    assign hs_rem              = voice_rem[req_id] - 24'(req_len);
    assign ptr_inc             = ADDR_WIDTH'({req_len, 2'b00});
    assign len_sel             = (voice_rem[idx] < 24'(BURST_LEN)) ? voice_rem[idx][7:0] : 8'(BURST_LEN);

    // The next-state decision must see a write landing in the same cycle.
    always_comb begin
        valid_next = voice_valid;
        if (wr_apply) begin
            valid_next[voice_wr_id] = (voice_wr_len != '0);
        end
        any_valid = |valid_next;
        top_id    = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (valid_next[i]) begin
                top_id = 6'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        capture    = 1'b0;
        idx_inc    = 1'b0;
        last_hit   = 1'b0;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && any_valid) begin
                        state_next = SCAN;
                        capture    = 1'b1;
                    end
                end
                SCAN: begin
                    if (voice_valid[idx]) begin
                        state_next = ISSUE;
                        load_req   = 1'b1;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
                ISSUE: begin
                    if (hs) begin
                        if (idx == last_id) begin
                            state_next = WAIT_RX;
                            last_hit   = 1'b1;
                        end else begin
                            state_next = SCAN;
                            idx_inc    = 1'b1;
                        end
                    end
                end
                WAIT_RX: begin
                    if (all_samples_received) begin
                        if (any_valid) begin
                            state_next = SCAN;
                            capture    = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx               <= '0;
            last_id           <= '0;
            req_tvalid        <= 1'b0;
            req_addr          <= '0;
            req_len           <= '0;
            req_id            <= '0;
            last_request_sent <= 1'b0;
            last_request_id   <= '0;
        end else begin
            if (stop || capture) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 6'd1;
            end
            if (capture) begin
                last_id <= top_id;
            end
            if (stop) begin
                req_tvalid <= 1'b0;
            end else if (load_req) begin
                req_tvalid <= 1'b1;
            end else if (hs) begin
                req_tvalid <= 1'b0;
            end
            if (load_req) begin
                req_addr <= voice_ptr[idx];
                req_len  <= len_sel;
                req_id   <= idx;
            end
            last_request_sent <= last_hit;
            if (last_hit) begin
                last_request_id <= idx;
            end
        end
    end

    // Writes only happen in IDLE/WAIT_RX and handshakes only in ISSUE, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            voice_valid <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                voice_ptr[i] <= '0;
                voice_rem[i] <= '0;
`ifdef DMA_REQ_LOOP_EN
                voice_start[i] <= '0;
                voice_len[i]   <= '0;
`endif
            end
        end else if (wr_apply) begin
            voice_valid[voice_wr_id] <= (voice_wr_len != '0);
            voice_ptr[voice_wr_id]   <= voice_wr_addr;
            voice_rem[voice_wr_id]   <= voice_wr_len;
`ifdef DMA_REQ_LOOP_EN
            voice_start[voice_wr_id] <= voice_wr_addr;
            voice_len[voice_wr_id]   <= voice_wr_len;
`endif
        end else if (hs) begin
            voice_ptr[req_id] <= voice_ptr[req_id] + ptr_inc;
            voice_rem[req_id] <= hs_rem;
            if (hs_rem == '0) begin
`ifdef DMA_REQ_LOOP_EN
                voice_ptr[req_id] <= voice_start[req_id];
                voice_rem[req_id] <= voice_len[req_id];
`else
                voice_valid[req_id] <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sample_dma_requester.sv
// Self-checking bench for sample_dma_requester: directed scenarios plus randomized batches against a voice-table model.
// Follows DMA_REQ_LOOP_EN so the model matches the build.
module tb_sample_dma_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        voice_wr_en;
    logic        voice_wr_ready;
    logic [5:0]  voice_wr_id;
    logic [31:0] voice_wr_addr;
    logic [23:0] voice_wr_len;
    logic        req_tvalid;
    logic        req_tready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [5:0]  req_id;
    logic        last_request_sent;
    logic [5:0]  last_request_id;
    logic        all_samples_invalid;
    logic        all_samples_received;

    always #5 clk = ~clk;

    sample_dma_requester #(
        .NUM_VOICES(64),
        .BURST_LEN (16),
        .ADDR_WIDTH(32)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .stop                (stop),
        .voice_wr_en         (voice_wr_en),
        .voice_wr_ready      (voice_wr_ready),
        .voice_wr_id         (voice_wr_id),
        .voice_wr_addr       (voice_wr_addr),
        .voice_wr_len        (voice_wr_len),
        .req_tvalid          (req_tvalid),
        .req_tready          (req_tready),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .req_id              (req_id),
        .last_request_sent   (last_request_sent),
        .last_request_id     (last_request_id),
        .all_samples_invalid (all_samples_invalid),
        .all_samples_received(all_samples_received)
    );

`ifdef DMA_REQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference voice table
    logic [31:0] m_ptr   [64];
    logic [31:0] m_start [64];
    int unsigned m_rem   [64];
    int unsigned m_len   [64];
    bit          m_valid [64];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_any();
        for (int i = 0; i < 64; i++) if (m_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_consume(input int id, input int unsigned len);
        m_ptr[id] = m_ptr[id] + 32'(len * 4);
        m_rem[id] = m_rem[id] - len;
        if (m_rem[id] == 0) begin
            if (LOOP) begin
                m_ptr[id] = m_start[id];
                m_rem[id] = m_len[id];
            end else begin
                m_valid[id] = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input bit chk);
        reset = 1'b1; start = 1'b0; stop = 1'b0; voice_wr_en = 1'b0;
        voice_wr_id = '0; voice_wr_addr = '0; voice_wr_len = '0;
        req_tready = 1'b0; all_samples_received = 1'b0;
        tick();
        tick();
        if (chk) begin
            check_eq("rst_tvalid", req_tvalid, 0);
            check_eq("rst_addr", req_addr, 0);
            check_eq("rst_len", req_len, 0);
            check_eq("rst_id", req_id, 0);
            check_eq("rst_last_sent", last_request_sent, 0);
            check_eq("rst_last_id", last_request_id, 0);
            check_eq("rst_invalid", all_samples_invalid, 1);
            check_eq("rst_wr_ready", voice_wr_ready, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0; m_ptr[i] = '0; m_start[i] = '0; m_rem[i] = 0; m_len[i] = 0;
        end
        tick();
        if (chk) check_eq("post_rst_wr_ready", voice_wr_ready, 1);
    endtask

    task automatic wr(input int id, input logic [31:0] addr, input int unsigned len, input bit rx);
        bit acc;
        voice_wr_en = 1'b1; voice_wr_id = 6'(id); voice_wr_addr = addr; voice_wr_len = 24'(len);
        all_samples_received = rx;
        acc = voice_wr_ready;
        tick();
        voice_wr_en = 1'b0;
        all_samples_received = 1'b0;
        if (acc) begin
            m_valid[id] = (len != 0); m_ptr[id] = addr; m_start[id] = addr;
            m_rem[id] = len; m_len[id] = len;
        end
    endtask

    task automatic wait_tvalid();
        int n = 0;
        while (!req_tvalid && n < 200) begin
            tick();
            n++;
        end
        check_eq("wait_tvalid", req_tvalid, 1);
    endtask

    // Acts as the bridge for one batch; expected requests come from the model in ascending voice order.
    task automatic do_batch(input int pct, input int stall0);
        logic [31:0] e_addr[$];
        int unsigned e_len[$];
        int          e_id[$];
        logic [31:0] p_addr;
        logic [7:0]  p_len;
        logic [5:0]  p_id;
        logic        p_valid, p_ready;
        int got = 0, budget = 0, stalled = 0;
        bit is_last;
        for (int i = 0; i < 64; i++) begin
            if (m_valid[i]) begin
                e_addr.push_back(m_ptr[i]);
                e_len.push_back(m_rem[i] < 16 ? m_rem[i] : 16);
                e_id.push_back(i);
            end
        end
        if (e_id.size() == 0) return;
        while (got < e_id.size() && budget < 3000) begin
            if (req_tvalid && stalled < stall0) begin
                req_tready = 1'b0;
                stalled++;
            end else begin
                req_tready = ($urandom_range(0, 99) < pct);
            end
            p_valid = req_tvalid; p_ready = req_tready;
            p_addr = req_addr; p_len = req_len; p_id = req_id;
            tick();
            budget++;
            if (p_valid && p_ready) begin
                is_last = (got == e_id.size() - 1);
                check_eq("req_addr", p_addr, e_addr[got]);
                check_eq("req_len", p_len, e_len[got]);
                check_eq("req_id", p_id, e_id[got]);
                check_eq("last_sent", last_request_sent, is_last);
                if (is_last) check_eq("last_id", last_request_id, e_id[got]);
                m_consume(e_id[got], e_len[got]);
                got++;
            end else if (p_valid) begin
                check_eq("hold_tvalid", req_tvalid, 1);
                check_eq("hold_addr", req_addr, p_addr);
                check_eq("hold_len", req_len, p_len);
                check_eq("hold_id", req_id, p_id);
            end
        end
        req_tready = 1'b0;
        if (got < e_id.size()) check_eq("batch_timeout", got, e_id.size());
        check_eq("wrx_wr_ready", voice_wr_ready, 1);
        check_eq("wrx_tvalid", req_tvalid, 0);
        check_eq("invalid_flag", all_samples_invalid, !m_any());
    endtask

    task automatic rx_pulse(input int delay);
        repeat (delay) tick();
        if (delay > 0) check_eq("last_pulse_width", last_request_sent, 0);
        all_samples_received = 1'b1;
        tick();
        all_samples_received = 1'b0;
    endtask

    task automatic run_all(input int pct, input int max_b);
        for (int b = 0; b < max_b && m_any(); b++) begin
            do_batch(pct, 0);
            rx_pulse($urandom_range(0, 3));
        end
    endtask

    initial begin
        do_reset(1'b1);

        // Single voice, three batches, start latency
        wr(0, 32'h1000, 40, 1'b0);
        start = 1'b1;
        tick();
        check_eq("lat_n1_tvalid", req_tvalid, 0);
        tick();
        check_eq("lat_n2_tvalid", req_tvalid, 1);
        check_eq("lat_n2_addr", req_addr, 32'h1000);
        for (int b = 0; b < 3; b++) begin
            do_batch(100, 0);
            rx_pulse(1);
        end
        repeat (3) tick();
        check_eq("t1_invalid", all_samples_invalid, !m_any());
        check_eq("t1_tvalid", req_tvalid, m_any());
        check_eq("t1_wr_ready", voice_wr_ready, !m_any());

        // Two voices, five-cycle stall on the first request
        do_reset(1'b1);
        wr(3, 32'h3000_0000, 10, 1'b0);
        wr(10, 32'h0A00_0000, 50, 1'b0);
        start = 1'b1;
        do_batch(60, 5);
        rx_pulse(2);
        run_all(70, 6);

        // all_samples_received outside WAIT_RX, then stop while stalled
        do_reset(1'b1);
        all_samples_received = 1'b1;
        tick();
        all_samples_received = 1'b0;
        check_eq("rx_idle_wr_ready", voice_wr_ready, 1);
        wr(5, 32'h3000, 30, 1'b0);
        start = 1'b1;
        wait_tvalid();
        all_samples_received = 1'b1;
        tick();
        all_samples_received = 1'b0;
        tick();
        check_eq("rx_issue_tvalid", req_tvalid, 1);
        check_eq("rx_issue_addr", req_addr, 32'h3000);
        stop = 1'b1; start = 1'b0;
        tick();
        stop = 1'b0;
        check_eq("stop_tvalid", req_tvalid, 0);
        check_eq("stop_wr_ready", voice_wr_ready, 1);
        check_eq("stop_last_sent", last_request_sent, 0);
        tick();
        check_eq("stop_idle_tvalid", req_tvalid, 0);
        start = 1'b1;
        do_batch(100, 0);
        rx_pulse(0);
        run_all(50, 6);

        // Table frozen during a batch; writes in WAIT_RX, including one coinciding with all_samples_received
        do_reset(1'b1);
        wr(4, 32'h4000, 20, 1'b0);
        start = 1'b1;
        wait_tvalid();
        check_eq("issue_wr_ready", voice_wr_ready, 0);
        wr(7, 32'h7000, 8, 1'b0);
        check_eq("frozen_invalid7", m_valid[7], 0);
        do_batch(80, 0);
        wr(7, 32'h7000, 8, 1'b0);
        rx_pulse(0);
        do_batch(80, 0);
        check_eq("t5_last_id", last_request_id, LOOP ? 7 : 7);
        if (!LOOP) begin
            rx_pulse(1);
            wr(2, 32'h2200, 4, 1'b0);
            do_batch(100, 0);
            wr(9, 32'h9000, 5, 1'b1);
            do_batch(100, 0);
            check_eq("coincide_last_id", last_request_id, 9);
            rx_pulse(0);
        end

`ifdef DMA_REQ_LOOP_EN
        do_reset(1'b1);
        wr(1, 32'h2000, 20, 1'b0);
        start = 1'b1;
        for (int b = 0; b < 3; b++) begin
            do_batch(100, 0);
            rx_pulse(1);
        end
        check_eq("loop_still_valid", all_samples_invalid, 0);
        check_eq("loop_model_ptr", m_ptr[1], 32'h2040);
`endif

        // Randomized voice sets, stalls and WAIT_RX writes
        for (int it = 0; it < 8; it++) begin
            int nv;
            do_reset(1'b0);
            nv = $urandom_range(1, 4);
            for (int v = 0; v < nv; v++) begin
                logic [31:0] a;
                a = $urandom();
                a[1:0] = 2'b00;
                if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFC0;
                wr($urandom_range(0, 63), a, $urandom_range(1, 40), 1'b0);
            end
            start = 1'b1;
            for (int b = 0; b < 6 && m_any(); b++) begin
                int mode;
                do_batch($urandom_range(30, 100), $urandom_range(0, 2));
                mode = $urandom_range(0, 2);
                if (mode == 0) begin
                    rx_pulse($urandom_range(0, 3));
                end else if (mode == 1) begin
                    wr($urandom_range(0, 63), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 40), 1'b0);
                    rx_pulse(0);
                end else begin
                    wr($urandom_range(0, 63), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom_range(0, 40), 1'b1);
                end
            end
        end

        do_reset(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
